// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-into-one arbiter for the sram protocol. It merges the CPU core's
// instruction-fetch port (i_*) and load/store port (d_*) onto a single
// unified sram slave (m_*) with a fixed 1-cycle read latency.
//
// Conflicting requests are resolved in the same cycle. The loser is stalled
// and must hold its request. Each read response is steered back to the port
// that issued it and is held there until that port's next response.
//
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   : round-robin on conflict cycles. The winner is
//                               the port that did not win the last conflict.
//                   undefined : fixed DATA priority. A continuous stream of
//                               data requests can starve INST.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   i_en / i_addr       instruction read request
//   i_we / i_data_w     present for protocol symmetry, ignored (read-only port)
//   i_data_r, i_rvalid  instruction read data; i_rvalid pulses when fresh
//   i_stall             instruction request not accepted this cycle
//   d_en / d_we         data request; d_we == 0 is a read
//   d_addr / d_data_w   data address and store data
//   d_data_r, d_rvalid  load read data; d_rvalid pulses when fresh
//   d_stall             data request not accepted this cycle
//   m_en / m_we         memory enable and byte write enables
//   m_addr / m_data_w   memory address and write data
//   m_data_r            memory read data, valid 1 cycle after an accepted read
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_w,
  output logic [DATA_W-1:0] i_data_r,
  output logic              i_rvalid,
  output logic              i_stall,

  input  logic              d_en,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_w,
  output logic [DATA_W-1:0] d_data_r,
  output logic              d_rvalid,
  output logic              d_stall,

  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_w,
  input  logic [DATA_W-1:0] m_data_r
);

  // Which port owns the read data arriving on m_data_r this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t            r_owner;
  owner_t            w_owner_next;
  logic [DATA_W-1:0] r_i_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_conflict;
  logic              w_data_wins;
  logic              w_grant_i;
  logic              w_grant_d;

  // The instruction port is read-only, so its write-side inputs have no
  // function. They are collected here so it is clear they are dropped on
  // purpose.
  logic              w_unused;
  assign w_unused = ^{i_we, i_data_w};

  assign w_conflict = i_en & d_en;

`ifdef SRAM_ARB_RR_EN
  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_t;

  port_t r_last_grant;

  // DATA wins a conflict only if INST won the previous one. Reset leaves
  // INST as the last grant, so DATA wins the first conflict.
  assign w_data_wins = (r_last_grant == PORT_INST);

  // last_grant only moves on conflict cycles. Uncontested grants do not
  // affect fairness.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= PORT_INST;
    end else if (w_conflict) begin
      r_last_grant <= w_grant_d ? PORT_DATA : PORT_INST;
    end
  end
`else
  // Fixed priority: DATA always wins a conflict.
  assign w_data_wins = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Grant and stall (combinational, same cycle as the request)
  // ---------------------------------------------------------------------------
  assign w_grant_d = d_en & (~i_en | w_data_wins);
  assign w_grant_i = i_en & (~d_en | ~w_data_wins);

  assign i_stall   = i_en & ~w_grant_i;
  assign d_stall   = d_en & ~w_grant_d;

  // ---------------------------------------------------------------------------
  // Memory drive. The instruction port never writes, so m_we is forced to
  // zero whenever INST holds the grant.
  // ---------------------------------------------------------------------------
  assign m_en     = w_grant_i | w_grant_d;
  assign m_we     = w_grant_d ? d_we : 4'b0000;
  assign m_addr   = w_grant_d ? d_addr : i_addr;
  assign m_data_w = w_grant_d ? d_data_w : '0;

  // ---------------------------------------------------------------------------
  // Response owner: a two-process state register. Writes produce no response,
  // so a data write leaves the owner at NONE.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_grant_i) begin
      w_owner_next = OWN_INST;
    end else if (w_grant_d && (d_we == 4'b0000)) begin
      w_owner_next = OWN_DATA;
    end
  end

  // An async reset clears the owner, which drops any outstanding response.
  // No rvalid can appear after reset until a new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response hold registers. In the response cycle the port sees m_data_r
  // directly. The hold register captures that value at the same edge, so the
  // data stays stable while the core stalls or idles.
  // ---------------------------------------------------------------------------
  // NOTE: the hold registers are reset, unlike a plain data path, because the
  // read-data outputs must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (r_owner == OWN_INST) r_i_hold <= m_data_r;
      if (r_owner == OWN_DATA) r_d_hold <= m_data_r;
    end
  end

  assign i_rvalid = (r_owner == OWN_INST);
  assign d_rvalid = (r_owner == OWN_DATA);
  assign i_data_r = i_rvalid ? m_data_r : r_i_hold;
  assign d_data_r = d_rvalid ? m_data_r : r_d_hold;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. A behavioural sram slave sits on the
// m_* side. The reference model holds a shadow word array and applies the
// grant rules directly. For every accepted read it pushes the expected data,
// tagged with its due cycle, into a per-port queue. A separate monitor checks
// each port on every falling edge:
//   - a due response must arrive with matching data;
//   - otherwise rvalid must be 0 and the data must hold the last delivery.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0;
  logic [3:0]    i_we = '0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data_w = '0;
  logic [DW-1:0] i_data_r;
  logic          i_rvalid, i_stall;
  logic          d_en = 1'b0;
  logic [3:0]    d_we = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_data_w = '0;
  logic [DW-1:0] d_data_r;
  logic          d_rvalid, d_stall;
  logic          m_en;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_w;
  logic [DW-1:0] m_data_r = '0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_we(i_we), .i_addr(i_addr), .i_data_w(i_data_w),
    .i_data_r(i_data_r), .i_rvalid(i_rvalid), .i_stall(i_stall),
    .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_data_w(d_data_w),
    .d_data_r(d_data_r), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_data_w(m_data_w),
    .m_data_r(m_data_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Behavioural sram slave. Reads land one cycle after the accepted read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (m_en) begin
      if (|m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_data_w[8*b +: 8];
      end else begin
        m_data_r <= mem[m_addr[9:2]];
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic [31:0] shadow [256];
  resp_t       iq[$];
  resp_t       dq[$];
  logic [31:0] i_last = '0;
  logic [31:0] d_last = '0;
`ifdef SRAM_ARB_RR_EN
  bit          rr_last_data = 1'b0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  // Monitor: checks both response ports on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (iq.size() > 0 && iq[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL i_resp_missing @cycle %0d: got none expected %h", cyc, iq[0].data);
        void'(iq.pop_front());
      end
      if (iq.size() > 0 && iq[0].due == cyc) begin
        check("i_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("i_data_r", i_data_r, iq[0].data);
        i_last = iq[0].data;
        void'(iq.pop_front());
      end else begin
        check("i_rvalid_idle", {31'd0, i_rvalid}, 32'd0);
        check("i_data_hold", i_data_r, i_last);
      end

      if (dq.size() > 0 && dq[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL d_resp_missing @cycle %0d: got none expected %h", cyc, dq[0].data);
        void'(dq.pop_front());
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        check("d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("d_data_r", d_data_r, dq[0].data);
        d_last = dq[0].data;
        void'(dq.pop_front());
      end else begin
        check("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
        check("d_data_hold", d_data_r, d_last);
      end
    end
  end

  // Drives one cycle of requests, checks the combinational grant outputs
  // against the arbitration rules, and updates the model.
  // Entered and left at posedge + 1.
  task automatic drive(input bit ie, input logic [31:0] ia,
                       input bit de, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd,
                       output bit gi, output bit gd);
    bit dwin;
    i_en = ie; i_addr = ia; i_we = 4'hF; i_data_w = $urandom;
    d_en = de; d_we = dw; d_addr = da; d_data_w = dd;
    #2;
`ifdef SRAM_ARB_RR_EN
    dwin = !rr_last_data;
`else
    dwin = 1'b1;
`endif
    gd = de && (!ie || dwin);
    gi = ie && !gd;
`ifdef SRAM_ARB_RR_EN
    if (ie && de) rr_last_data = gd;
`endif
    check("i_stall", {31'd0, i_stall}, {31'd0, ie && !gi});
    check("d_stall", {31'd0, d_stall}, {31'd0, de && !gd});
    check("m_en", {31'd0, m_en}, {31'd0, gi || gd});
    if (gi) begin
      check("m_addr_i", m_addr, ia);
      check("m_we_i", {28'd0, m_we}, 32'd0);
      iq.push_back('{cyc + 1, shadow[ia[9:2]]});
    end
    if (gd) begin
      check("m_addr_d", m_addr, da);
      check("m_we_d", {28'd0, m_we}, {28'd0, dw});
      if (dw != 4'b0000) begin
        check("m_data_w", m_data_w, dd);
        for (int b = 0; b < 4; b++)
          if (dw[b]) shadow[da[9:2]][8*b +: 8] = dd[8*b +: 8];
      end else begin
        dq.push_back('{cyc + 1, shadow[da[9:2]]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit gi, gd;
    for (int k = 0; k < n; k++) drive(0, '0, 0, 4'h0, '0, '0, gi, gd);
  endtask

  // Asserts reset for one edge. The model drops any outstanding response and
  // clears both delivered-data values to zero.
  task automatic do_reset();
    rst = 1'b1;
    i_en = 1'b0; d_en = 1'b0;
    iq.delete(); dq.delete();
    i_last = '0; d_last = '0;
`ifdef SRAM_ARB_RR_EN
    rr_last_data = 1'b0;
`endif
    #2;
    check("rst_i_data_r", i_data_r, 32'd0);
    check("rst_d_data_r", d_data_r, 32'd0);
    check("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit gi, gd;
    bit pi, pd;
    logic [31:0] ia, da, dd;
    logic [3:0]  dw;

    do_reset();

    // Single instruction read of a known word.
    drive(0, '0, 1, 4'hF, 32'h10, 32'h24020005, gi, gd);
    drive(1, 32'h10, 0, 4'h0, '0, '0, gi, gd);
    idle(1);

    // Partial write produces no response. A read-back then shows the
    // merged low half.
    drive(0, '0, 1, 4'b0011, 32'h80, 32'hDEADBEEF, gi, gd);
    drive(0, '0, 1, 4'h0, 32'h80, '0, gi, gd);
    check("d_low_half", {16'd0, d_data_r[15:0]}, 32'h0000BEEF);
    idle(1);

    // Three conflicting cycles, then INST alone.
    for (int k = 0; k < 3; k++) drive(1, 32'h20, 1, 4'h0, 32'h24, '0, gi, gd);
    drive(1, 32'h20, 0, 4'h0, '0, '0, gi, gd);
    idle(1);

    // Back-to-back reads on consecutive cycles.
    drive(1, 32'h0, 0, 4'h0, '0, '0, gi, gd);
    drive(1, 32'h4, 0, 4'h0, '0, '0, gi, gd);
    drive(0, '0, 1, 4'h0, 32'h8, '0, gi, gd);
    idle(1);

    // Hold: the response stays stable through idle cycles.
    drive(0, '0, 1, 4'hF, 32'h30, 32'h11111111, gi, gd);
    drive(1, 32'h30, 0, 4'h0, '0, '0, gi, gd);
    idle(4);
    check("i_hold_value", i_data_r, 32'h11111111);

    // Reset in the cycle after an accepted read drops the response.
    drive(1, 32'h10, 0, 4'h0, '0, '0, gi, gd);
    do_reset();
    idle(1);
    drive(1, 32'h10, 0, 4'h0, '0, '0, gi, gd);
    idle(2);

    // Randomised traffic. A stalled request is held unchanged until granted.
    pi = 0; pd = 0; ia = '0; da = '0; dd = '0; dw = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1;
        ia = {$urandom_range(0, 65535), 16'h0} | ($urandom_range(0, 15) << 2);
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1;
        da = {$urandom_range(0, 65535), 16'h0} | ($urandom_range(0, 15) << 2);
        dw = ($urandom_range(0, 1) == 1) ? 4'(($urandom_range(0, 15))) : 4'h0;
        dd = $urandom;
      end
      drive(pi, ia, pd, dw, da, dd, gi, gd);
      if (gi) pi = 0;
      if (gd) pd = 0;
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-into-one arbiter for the sram protocol (en, we[3:0], addr, data_w, data_r).
- Sits directly downstream of the CPU core's instruction-fetch and load/store sram masters, and upstream of a single unified sram slave (on-chip block RAM).
- Memory has fixed 1-cycle read latency.
- Arbitrates conflicting requests, stalls the loser, and steers each read response back to the port that issued it.

Parameters:
- ADDR_W, 32, address width (matches the codebase address width macro).
- DATA_W, 32, data width (matches the codebase data width macro).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_en  input  1  instruction port request.
- i_we  input  4  instruction port byte write enables; ignored, instruction port is read-only.
- i_addr  input  ADDR_W  instruction address.
- i_data_w  input  DATA_W  unused; tied off internally.
- i_data_r  output  DATA_W  instruction read data.
- i_rvalid  output  1  pulses 1 in the cycle i_data_r carries a fresh response.
- i_stall  output  1  request not accepted this cycle; core must hold i_en/i_addr.
- d_en  input  1  data port request.
- d_we  input  4  data port byte write enables; 0 = read.
- d_addr  input  ADDR_W  data address.
- d_data_w  input  DATA_W  store data.
- d_data_r  output  DATA_W  load read data.
- d_rvalid  output  1  response-valid pulse for data port.
- d_stall  output  1  data request not accepted this cycle.
- m_en  output  1  memory enable.
- m_we  output  4  memory byte write enables.
- m_addr  output  ADDR_W  memory address.
- m_data_w  output  DATA_W  memory write data.
- m_data_r  input  DATA_W  memory read data, valid 1 cycle after an accepted read.

Behaviour:
- Reset (asynchronous, rst=1):
  - Response owner register = NONE.
  - i_data_r = d_data_r = 0; i_rvalid = d_rvalid = 0.
  - last_grant = INST.
  - Stalls follow their combinational equations.
- Grant (combinational, same cycle):
  - Only one of i_en/d_en high: that port is granted, its stall = 0.
  - Both high: the winner is granted, the loser's stall = 1.
  - Neither high: m_en = 0, m_we = 0, both stalls = 0.
  - Default winner is DATA (fixed priority).
- Memory drive:
  - m_en = 1 iff a grant exists.
  - m_addr / m_data_w / m_we come from the granted port.
  - m_we = 4'b0000 whenever INST is granted.
  - m_addr / m_data_w are don't-care when m_en = 0.
- Owner register (updated each clock edge):
  - INST if INST was granted.
  - DATA if DATA was granted with d_we == 0.
  - NONE otherwise; writes produce no response.
- Response (registered, 1 cycle after grant):
  - owner == INST: i_data_r <= m_data_r, i_rvalid = 1.
  - owner == DATA: d_data_r <= m_data_r, d_rvalid = 1.
  - A port without a response holds its last delivered data; its rvalid = 0.
  - Data is captured into the hold register, so it stays stable while the core stalls.
- Back-to-back: a new grant is allowed every cycle; throughput is 1 access/cycle.
- Simultaneous events: a response for request N and a grant for request N+1 in the same cycle are independent.
- Reset mid-operation: an outstanding response is dropped; no rvalid after rst deasserts until a new grant.
- Address wrap-around is irrelevant; addresses pass through unmodified.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined:
  - Conflict winner is the port not in last_grant (round-robin).
  - last_grant updates only on conflict cycles.
  - Neither port can be stalled two consecutive conflicting cycles.
- Undefined:
  - Fixed DATA priority; last_grant is not implemented.
  - Continuous data requests may starve INST.

Test Plan:
- Only i_en=1, i_addr=0x00000010, memory word 0x24020005 -> i_stall=0, m_en=1, m_we=0; next cycle i_data_r=0x24020005, i_rvalid=1, d_rvalid=0.
- Only d_en=1, d_we=4'b0011, d_addr=0x80, d_data_w=0xDEADBEEF -> m_we=4'b0011, m_data_w=0xDEADBEEF; next cycle d_rvalid=0, owner NONE; subsequent read of 0x80 returns 0x????BEEF, low half 0xBEEF.
- i_en=d_en=1 for 3 cycles, fixed priority:
  - i_stall=1 all 3 cycles, d_stall=0.
  - With SRAM_ARB_RR_EN: grants DATA, INST, DATA and i_stall=1,0,1.
- Back-to-back reads: i@0x0, i@0x4, d@0x8 on consecutive cycles -> responses on consecutive cycles; i_rvalid=1,1 then d_rvalid=1; data matches each address.
- Hold: INST read returns 0x11111111, then idle 4 cycles -> i_data_r stays 0x11111111, i_rvalid=0.
- Assert rst in the cycle after an accepted read -> no rvalid pulse; i_data_r=d_data_r=0; first post-reset grant behaves normally.
